// File: rtl/pila_param.sv
// Return-address stack (LIFO) for the CPU control path: CALL pushes, RET pops.
// Adds a full-stack policy, push+pop replace, occupancy count and sticky error flags.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   push      push pc_addr this cycle
//   pop       pop the top entry this cycle
//   clr_err   synchronous clear of overflow/underflow
//   pc_addr   data to push
//   sp        top entry, 0 when empty (combinational)
//   count     number of valid entries, 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
//   overflow  sticky: push attempted while full
//   underflow sticky: pop attempted while empty
module pila_param #(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] pc_addr,
    output logic [WIDTH-1:0] sp,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int HW = $clog2(DEPTH);
    localparam logic [HW-1:0] LAST = HW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [HW-1:0]    head;
    logic [HW-1:0]    top;
    logic [HW-1:0]    head_inc;

    logic             wr_en;
    logic [HW-1:0]    wr_addr;
    logic [HW-1:0]    head_n;
    logic [CW-1:0]    count_n;
    logic             ovf_set;
    logic             unf_set;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign top      = (head == '0) ? LAST : head - HW'(1);
    assign head_inc = (head == LAST) ? '0 : head + HW'(1);
    assign sp       = empty ? '0 : mem[top];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = head;
        head_n  = head;
        count_n = count;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push && pop && !empty) begin
            // Replace top: a RET immediately followed by a CALL.
            wr_en   = 1'b1;
            wr_addr = top;
        end else if (push) begin
            // Also covers push+pop on empty, which pushes and flags the pop.
            unf_set = pop;
            if (!full) begin
                wr_en   = 1'b1;
                head_n  = head_inc;
                count_n = count + CW'(1);
            end else begin
                ovf_set = 1'b1;
                if (OVF_MODE != 0) begin
                    // Circular: the write slot is the oldest entry.
                    wr_en  = 1'b1;
                    head_n = head_inc;
                end
            end
        end else if (pop) begin
            if (!empty) begin
                head_n  = top;
                count_n = count - CW'(1);
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            head      <= head_n;
            count     <= count_n;
            overflow  <= ovf_set | (overflow & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= pc_addr;
        end
    end

endmodule

// File: tb/tb_pila_param.sv
// Directed bench for pila_param: DEPTH=4 stacks in drop (u0) and circular (u1) modes.
// Both instances share stimulus; expected values are hand-computed constants.
module tb_pila_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [9:0] pc_addr = '0;

    logic [9:0] sp0, sp1;
    logic [2:0] cnt0, cnt1;
    logic       full0, full1, empty0, empty1;
    logic       ovf0, ovf1, unf0, unf1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pila_param #(.WIDTH(10), .DEPTH(4), .OVF_MODE(0)) u0 (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .clr_err(clr_err), .pc_addr(pc_addr), .sp(sp0),
        .count(cnt0), .full(full0), .empty(empty0),
        .overflow(ovf0), .underflow(unf0)
    );

    pila_param #(.WIDTH(10), .DEPTH(4), .OVF_MODE(1)) u1 (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .clr_err(clr_err), .pc_addr(pc_addr), .sp(sp1),
        .count(cnt1), .full(full1), .empty(empty1),
        .overflow(ovf1), .underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic cyc(input logic pu, input logic po, input logic ce,
                       input logic [9:0] d);
        push = pu; pop = po; clr_err = ce; pc_addr = d;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    // Pop one entry, checking sp during the pop cycle.
    task automatic pop_chk(input string tag, input logic [9:0] e0,
                           input logic [9:0] e1);
        pop = 1'b1;
        #1;
        check({tag, "_sp0"}, 32'(sp0), 32'(e0));
        check({tag, "_sp1"}, 32'(sp1), 32'(e1));
        @(posedge clk); #1;
        pop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_sp", 32'(sp0), 0);
        check("rst_cnt", 32'(cnt0), 0);
        check("rst_empty", 32'(empty0), 1);
        check("rst_full", 32'(full0), 0);
        check("rst_flags", 32'({ovf0, unf0, ovf1, unf1}), 0);

        // Basic LIFO order.
        cyc(1, 0, 0, 10'h011);
        cyc(1, 0, 0, 10'h022);
        cyc(1, 0, 0, 10'h033);
        check("lifo_sp", 32'(sp0), 32'h033);
        check("lifo_cnt", 32'(cnt0), 3);
        pop_chk("lifo_p0", 10'h033, 10'h033);
        pop_chk("lifo_p1", 10'h022, 10'h022);
        pop_chk("lifo_p2", 10'h011, 10'h011);
        check("lifo_empty", 32'({empty0, empty1}), 32'b11);
        check("lifo_sp_end", 32'(sp0), 0);

        // Full policy: drop (u0) vs circular (u1).
        for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 10'(i));
        check("fill_full", 32'({full0, full1}), 32'b11);
        check("fill_ovf", 32'({ovf0, ovf1}), 0);
        cyc(1, 0, 0, 10'd5);
        check("ovf0_cnt", 32'(cnt0), 4);
        check("ovf0_sp", 32'(sp0), 4);
        check("ovf0_flag", 32'(ovf0), 1);
        cyc(1, 0, 0, 10'd6);
        check("ovf1_cnt", 32'(cnt1), 4);
        check("ovf1_sp", 32'(sp1), 6);
        check("ovf1_flag", 32'(ovf1), 1);
        check("ovf0_sp_keep", 32'(sp0), 4);
        pop_chk("ovf_p0", 10'd4, 10'd6);
        pop_chk("ovf_p1", 10'd3, 10'd5);
        pop_chk("ovf_p2", 10'd2, 10'd4);
        pop_chk("ovf_p3", 10'd1, 10'd3);
        check("ovf_empty", 32'({empty0, empty1}), 32'b11);

        // Push+pop replace, and push+pop on empty.
        cyc(0, 0, 1, 10'h0);
        check("clr_all", 32'({ovf0, unf0, ovf1, unf1}), 0);
        cyc(1, 0, 0, 10'h100);
        cyc(1, 1, 0, 10'h155);
        check("rep_cnt", 32'(cnt0), 1);
        check("rep_sp", 32'(sp0), 32'h155);
        check("rep_flags", 32'({ovf0, unf0}), 0);
        cyc(0, 1, 0, 10'h0);
        cyc(1, 1, 0, 10'h3FF);
        check("pp_empty_cnt", 32'(cnt0), 1);
        check("pp_empty_sp", 32'(sp0), 32'h3FF);
        check("pp_empty_unf", 32'({unf0, unf1}), 32'b11);
        cyc(0, 1, 0, 10'h0);
        check("pp_drain_cnt", 32'(cnt0), 0);

        // Underflow, clear, and clear losing to a same-cycle event.
        cyc(0, 0, 1, 10'h0);
        check("unf_clr0", 32'(unf0), 0);
        cyc(0, 1, 0, 10'h0);
        check("unf_set", 32'(unf0), 1);
        check("unf_cnt", 32'(cnt0), 0);
        cyc(0, 0, 1, 10'h0);
        check("unf_clr1", 32'(unf0), 0);
        cyc(0, 1, 1, 10'h0);
        check("unf_wins", 32'(unf0), 1);

        // Asynchronous reset mid-run, away from any edge.
        cyc(1, 0, 0, 10'h00A);
        cyc(1, 0, 0, 10'h00B);
        cyc(1, 0, 0, 10'h00C);
        check("ar_cnt_pre", 32'(cnt0), 3);
        #2 reset = 1'b0;
        #1;
        check("ar_sp", 32'(sp0), 0);
        check("ar_cnt", 32'(cnt0), 0);
        check("ar_empty", 32'(empty0), 1);
        check("ar_flags", 32'({ovf0, unf0, ovf1, unf1}), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        cyc(1, 0, 0, 10'h2AA);
        check("ar_push_sp", 32'(sp0), 32'h2AA);
        check("ar_push_cnt", 32'(cnt0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
